// File: rtl/alu_iter_if.sv
// Request/response bundle for alu_iter: opcode and operands in, result and zero flag out.
interface alu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output alu_op, in_a, in_b, in_valid, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  alu_op, in_a, in_b, in_valid, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_iter.sv
// Small ALU with a valid/ready request and response. Shifts run one bit per cycle only when
// ALU_ITER_SHIFT_EN is defined; otherwise shift opcodes complete as undefined (result 0).
module alu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst_n,
  alu_iter_if.slave bus
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSltu = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
`ifdef ALU_ITER_SHIFT_EN
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;
`endif

  if ((1 << SHW) != WIDTH) begin : g_width_check
    $error("alu_iter: WIDTH must be a power of two equal to 2**SHW");
  end

`ifdef ALU_ITER_SHIFT_EN
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`endif

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] alu_res;

`ifdef ALU_ITER_SHIFT_EN
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] work_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] shift_step;
  logic [SHW-1:0]   shamt;
  logic             start_shift;

  assign shamt       = bus.in_b[SHW-1:0];
  assign start_shift = (bus.alu_op inside {OpSll, OpSrl, OpSra}) && (shamt != '0);

  always_comb begin
    case (op_q)
      OpSll:   shift_step = {work_q[WIDTH-2:0], 1'b0};
      OpSra:   shift_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shift_step = {1'b0, work_q[WIDTH-1:1]};
    endcase
  end
`endif

  // Single-cycle result; a zero-length shift is just the operand passed through.
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      OpAnd:  alu_res = bus.in_a & bus.in_b;
      OpOr:   alu_res = bus.in_a | bus.in_b;
      OpAdd:  alu_res = bus.in_a + bus.in_b;
      OpSub:  alu_res = bus.in_a - bus.in_b;
      OpXor:  alu_res = bus.in_a ^ bus.in_b;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, bus.in_a < bus.in_b};
`ifdef ALU_ITER_SHIFT_EN
      OpSll, OpSrl, OpSra: alu_res = bus.in_a;
`endif
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
`ifdef ALU_ITER_SHIFT_EN
      cnt_q       <= '0;
      work_q      <= '0;
      op_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
`ifdef ALU_ITER_SHIFT_EN
            if (start_shift) begin
              op_q    <= bus.alu_op;
              work_q  <= bus.in_a;
              cnt_q   <= shamt;
              state_q <= StShift;
            end else begin
`else
            begin
`endif
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
`ifdef ALU_ITER_SHIFT_EN
        // result_q only changes on the final step, so partial shifts are never visible.
        StShift: begin
          work_q <= shift_step;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_q    <= shift_step;
            zero_q      <= (shift_step == '0);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
`endif
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule
